// File: rtl/act_share_scheduler.sv
// Two-requester scheduler sharing one multi-cycle accumulate datapath (IDLE/LOAD/RUN/DONE).
// Optional macro PRIO_REQ1_EN: fixed priority to req1 on ties instead of round-robin.
module act_share_scheduler #(
   parameter int DW   = 8,
   parameter int HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req1,
   input  logic          req2,
   input  logic [DW-1:0] d1,
   input  logic [DW-1:0] d2,
   output logic          gnt1,
   output logic          gnt2,
   output logic          done,
   output logic [7:0]    c1,
   output logic [DW-1:0] x,
   output logic [DW-1:0] y,
   output logic [7:0]    act1,
   output logic [7:0]    act2,
   output logic [1:0]    i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [7:0] LAST_RUN = 8'(HOLD - 1);

   logic win2;
   logic pick2;
   logic run_end;

   assign run_end = (i == S_RUN) && (c1 == LAST_RUN);

`ifdef PRIO_REQ1_EN
   always_comb pick2 = req2 & ~req1;
`else
   // last2 resets high so requester 1 takes the first tie
   logic last2;

   always_comb pick2 = req2 & (~req1 | ~last2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last2 <= 1'b1;
      else if (run_end) last2 <= win2;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i    <= S_IDLE;
         gnt1 <= 1'b0;
         gnt2 <= 1'b0;
         done <= 1'b0;
         c1   <= '0;
         x    <= '0;
         y    <= '0;
         act1 <= '0;
         act2 <= '0;
         win2 <= 1'b0;
      end else begin
         gnt1 <= 1'b0;
         gnt2 <= 1'b0;
         done <= 1'b0;
         case (i)
            S_IDLE: begin
               if (req1 | req2) begin
                  win2 <= pick2;
                  x    <= pick2 ? d2 : d1;
                  gnt1 <= ~pick2;
                  gnt2 <= pick2;
                  i    <= S_LOAD;
               end
            end
            S_LOAD: begin
               y  <= x;
               c1 <= '0;
               i  <= S_RUN;
            end
            S_RUN: begin
               y  <= y + x;
               c1 <= c1 + 8'd1;
               // done and activity count become visible together in the DONE cycle
               if (run_end) begin
                  i    <= S_DONE;
                  done <= 1'b1;
                  if (win2) begin
                     if (act2 != 8'hFF) act2 <= act2 + 8'd1;
                  end else begin
                     if (act1 != 8'hFF) act1 <= act1 + 8'd1;
                  end
               end
            end
            default: i <= S_IDLE;
         endcase
      end
   end

endmodule
